// File: rtl/stream_mux_pkg.sv
// Shared constants and round-robin search helper for the stream mux.
// The search is written for a fixed maximum width and trimmed by callers.
package stream_mux_pkg;

  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;
  localparam int MAX_CH   = 64;
  localparam int IDX_W    = 6;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_grant_t;

  // First valid channel after ptr, wrapping at n-1 -> 0.
  function automatic rr_grant_t rr_next(
    input int                n,
    input int                ptr,
    input logic [MAX_CH-1:0] vld
  );
    rr_grant_t g;
    int c;
    g = '0;
    for (int k = 1; k <= MAX_CH; k++) begin
      if (k <= n && !g.found) begin
        c = ptr + k;
        if (c >= n) c = c - n;
        if (vld[c]) begin
          g.found = 1'b1;
          g.idx   = IDX_W'(c);
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/stream_mux_nw_rr_arbiter.sv
// Round-robin arbiter: picks the first valid channel after ptr.
// Purely combinational; the pointer lives in the parent.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  valid_vec,
  input  logic [SEL_W-1:0] ptr,
  input  logic             en,
  output logic [SEL_W-1:0] grant_idx,
  output logic             grant_found
);

  logic [MAX_CH-1:0] vec;
  rr_grant_t         g;
  logic              unused_idx;

  always_comb begin
    vec = '0;
    vec[N_CH-1:0] = valid_vec;
    g = rr_next(N_CH, int'(ptr), vec);
    grant_idx   = g.idx[SEL_W-1:0];
    grant_found = en & g.found;
  end

  assign unused_idx = ^g.idx;

endmodule

// File: rtl/stream_mux_nw.sv
// N-channel valid/ready stream mux with a one-entry registered output.
// Channel choice is either an external select or round-robin.
module stream_mux_nw
  import stream_mux_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int DATA_W = 4,
  parameter int MODE   = MODE_SEL,
  parameter int SEL_W  = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH*DATA_W-1:0] in_data,
  input  logic [N_CH-1:0]        in_valid,
  output logic [N_CH-1:0]        in_ready,
  input  logic [SEL_W-1:0]       sel,
  output logic [DATA_W-1:0]      out_data,
  output logic [SEL_W-1:0]       out_chan,
  output logic                   out_valid,
  input  logic                   out_ready
);

  logic              load;
  logic              en;
  logic              hit;
  logic              xfer;
  logic [SEL_W-1:0]  tgt;
  logic [DATA_W-1:0] xdata;

  assign load = !out_valid | out_ready;
  assign en   = load & !rst;

  if (MODE == MODE_RR) begin : g_rr
    logic [SEL_W-1:0] ptr;
    logic             unused_sel;

    assign unused_sel = ^sel;

    rr_arbiter #(
      .N_CH (N_CH),
      .SEL_W(SEL_W)
    ) u_arb (
      .valid_vec  (in_valid),
      .ptr        (ptr),
      .en         (en),
      .grant_idx  (tgt),
      .grant_found(hit)
    );

    // Reset to the last channel so channel 0 wins first.
    always_ff @(posedge clk) begin
      if (rst)
        ptr <= SEL_W'(N_CH - 1);
      else if (xfer)
        ptr <= tgt;
    end
  end else begin : g_sel
    assign tgt = sel;
    assign hit = 1'b1;
  end

  always_comb begin
    in_ready = '0;
    xdata    = '0;
    for (int i = 0; i < N_CH; i++) begin
      in_ready[i] = en & hit & (tgt == SEL_W'(i));
      if (in_ready[i])
        xdata = in_data[i*DATA_W +: DATA_W];
    end
  end

  assign xfer = |(in_valid & in_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= xdata;
      out_chan  <= tgt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_nw.sv
// Scoreboard bench for stream_mux_nw: one select-mode and one
// round-robin instance share clock and reset.
module tb_stream_mux_nw;

  typedef struct packed {
    logic [1:0] chan;
    logic [3:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] d0, d1;
  logic [3:0]  v0, v1;
  logic [3:0]  ir0, ir1;
  logic [1:0]  sel0, sel1;
  logic [3:0]  od0, od1;
  logic [1:0]  oc0, oc1;
  logic        ov0, ov1;
  logic        ordy0, ordy1;

  beat_t q0[$];
  beat_t q1[$];
  int checks   = 0;
  int failures = 0;

  logic [3:0] vals [4] = '{4'h8, 4'h9, 4'hA, 4'hB};
  logic [1:0] fair [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
  logic [1:0] sprs [7] = '{2'd1, 2'd3, 2'd1, 2'd3, 2'd3, 2'd3, 2'd3};

  always #5 clk = ~clk;

  stream_mux_nw #(.N_CH(4), .DATA_W(4), .MODE(0)) u_sel (
    .clk(clk), .rst(rst), .in_data(d0), .in_valid(v0),
    .in_ready(ir0), .sel(sel0), .out_data(od0), .out_chan(oc0),
    .out_valid(ov0), .out_ready(ordy0)
  );

  stream_mux_nw #(.N_CH(4), .DATA_W(4), .MODE(1)) u_rr (
    .clk(clk), .rst(rst), .in_data(d1), .in_valid(v1),
    .in_ready(ir1), .sel(sel1), .out_data(od1), .out_chan(oc1),
    .out_valid(ov1), .out_ready(ordy1)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (ov0 && ordy0) begin
      if (q0.size() == 0) begin
        checks++; failures++;
        $display("FAIL sel_extra_beat actual=%0h required=none", od0);
      end else begin
        e = q0.pop_front();
        chk("sel_chan", 32'(oc0), 32'(e.chan));
        chk("sel_data", 32'(od0), 32'(e.data));
      end
    end
    if (ov1 && ordy1) begin
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL rr_extra_beat actual=%0h required=none", od1);
      end else begin
        e = q1.pop_front();
        chk("rr_chan", 32'(oc1), 32'(e.chan));
        chk("rr_data", 32'(od1), 32'(e.data));
      end
    end
  end

  initial begin
    rst = 1'b1;
    d0 = 16'hBA98; d1 = 16'hBA98;
    v0 = 4'hF; v1 = 4'hF;
    sel0 = 2'd0; sel1 = 2'd0;
    ordy0 = 1'b1; ordy1 = 1'b1;

    // Reset with all inputs valid
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_ov_sel", 32'(ov0), 0);
      chk("rst_od_sel", 32'(od0), 0);
      chk("rst_ir_sel", 32'(ir0), 0);
      chk("rst_ov_rr", 32'(ov1), 0);
      chk("rst_od_rr", 32'(od1), 0);
      chk("rst_ir_rr", 32'(ir1), 0);
    end
    rst = 1'b0;
    v0 = 4'h0; v1 = 4'h0;
    step();

    // Select sweep
    v0 = 4'hF;
    for (int s = 0; s < 4; s++) begin
      sel0 = 2'(s);
      q0.push_back('{chan: 2'(s), data: vals[s]});
      step();
    end
    v0 = 4'h0;
    sel0 = 2'd2;
    #1;
    chk("sel_ready_no_valid", 32'(ir0), 32'h4);
    step(); step();
    chk("sel_drained", 32'(ov0), 0);

    // Backpressure
    v0 = 4'hF;
    sel0 = 2'd0;
    q0.push_back('{chan: 2'd0, data: 4'h8});
    step();
    ordy0 = 1'b0;
    sel0 = 2'd1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_ready", 32'(ir0), 0);
      chk("bp_hold", 32'(od0), 32'h8);
      chk("bp_valid", 32'(ov0), 1);
      step();
      #1;
    end
    ordy0 = 1'b1;
    q0.push_back('{chan: 2'd1, data: 4'h9});
    step();
    v0 = 4'h0;
    step(); step();
    chk("bp_drained", 32'(ov0), 0);

    // Round-robin fairness
    v1 = 4'hF;
    for (int k = 0; k < 8; k++) begin
      q1.push_back('{chan: fair[k], data: vals[fair[k]]});
      step();
    end

    // Sparse then single-channel wrap
    v1 = 4'b1010;
    #1;
    chk("rr_ready_onehot", 32'(ir1), 32'h2);
    for (int k = 0; k < 7; k++) begin
      if (k == 4) v1 = 4'b1000;
      q1.push_back('{chan: sprs[k], data: vals[sprs[k]]});
      step();
    end
    v1 = 4'h0;
    step(); step();
    chk("rr_drained", 32'(ov1), 0);

    // Reset while both outputs are stalled
    v0 = 4'b1000; sel0 = 2'd3;
    v1 = 4'b0100;
    step();
    ordy0 = 1'b0; ordy1 = 1'b0;
    v0 = 4'hF; v1 = 4'hF;
    #1;
    chk("stall_ir_sel", 32'(ir0), 0);
    chk("stall_ir_rr", 32'(ir1), 0);
    chk("stall_ov_rr", 32'(ov1), 1);
    chk("stall_od_rr", 32'(od1), 32'hA);
    step();
    chk("stall_od_sel", 32'(od0), 32'hB);
    rst = 1'b1;
    #1;
    chk("rst_cycle_ir_sel", 32'(ir0), 0);
    chk("rst_cycle_ir_rr", 32'(ir1), 0);
    step();
    chk("midrst_ov_sel", 32'(ov0), 0);
    chk("midrst_ov_rr", 32'(ov1), 0);
    rst = 1'b0;
    ordy0 = 1'b1; ordy1 = 1'b1;
    sel0 = 2'd0;
    q0.push_back('{chan: 2'd0, data: 4'h8});
    q1.push_back('{chan: 2'd0, data: 4'h8});
    step();
    v0 = 4'h0; v1 = 4'h0;
    step(); step();

    chk("sel_queue_empty", 32'(q0.size()), 0);
    chk("rr_queue_empty", 32'(q1.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
